booth_r4_seq: RTL

//  Parametrised sequential radix-4 Booth multiplier: W x W -> 2W product over W/2+1 iterations.

---
 rtl/booth_pkg.sv | 21 ++
 rtl/booth_r4_recode.sv | 43 ++++
 rtl/booth_r4_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier family.
package booth_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_t;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic neg;
    logic two;
    logic zero;
  } booth_sel_t;

  localparam booth_sel_t SEL_ZERO = '{neg: 1'b0, two: 1'b0, zero: 1'b1};

  // Operand width after sign/zero extension, so the last triplet sees the extension bits.
  function automatic int ext_w(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth digit recoder: multiplier triplet -> {neg, two, zero} and the
// inverted-or-plain partial product; the +1 of a negation is left to the adder's carry-in.
module booth_r4_recode
  import booth_pkg::*;
#(
  parameter int WIDTH = 224
) (
  input  logic [2:0]              trip,
  input  logic [ext_w(WIDTH)-1:0] m,
  output booth_sel_t              sel,
  output logic [ext_w(WIDTH):0]   pp
);

  localparam int EXT = ext_w(WIDTH);

  digit_t     digit;
  logic [EXT:0] mag;

  always_comb begin
    unique case (trip)
      3'b000, 3'b111: digit = ZERO;
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      default:        digit = NEG1;
    endcase
  end

  always_comb begin
    sel.neg  = (digit == NEG1) || (digit == NEG2);
    sel.two  = (digit == POS2) || (digit == NEG2);
    sel.zero = (digit == ZERO);
    if (sel.zero) begin
      mag = '0;
    end else if (sel.two) begin
      mag = {m, 1'b0};
    end else begin
      mag = {m[EXT-1], m};
    end
    pp = mag ^ {(EXT + 1){sel.neg}};
  end

endmodule

// File: rtl/booth_r4_seq.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH over WIDTH/2+1 steps,
// with start/busy/done handshake and signed/unsigned operand extension at capture.
module booth_r4_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 224,
  parameter int CNT_W = $clog2(WIDTH / 2 + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   c
);

  localparam int EXT     = ext_w(WIDTH);
  localparam int ACC_W   = EXT + 1;
  localparam int N_STEPS = WIDTH / 2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_STEPS - 1);

  state_t               state_q, state_d;
  logic [EXT-1:0]       m_q, m_d;
  logic [EXT-1:0]       mul_q, mul_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 prev_q, prev_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   c_q, c_d;
  logic                 done_q, done_d;

  booth_sel_t           sel;
  logic [ACC_W-1:0]     pp;
  logic [ACC_W-1:0]     sum;
  logic [ACC_W-1:0]     acc_sh;
  logic [EXT-1:0]       mul_sh;

  booth_r4_recode #(.WIDTH(WIDTH)) u_recode (
    .trip ({mul_q[1:0], prev_q}),
    .m    (m_q),
    .sel  (sel),
    .pp   (pp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    c    = c_q;
  end

  // One step: add the recoded partial product, then shift the {acc, multiplier} pair right by 2.
  always_comb begin
    sum    = (sel == SEL_ZERO) ? acc_q : acc_q + pp + ACC_W'(sel.neg);
    acc_sh = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
    mul_sh = {sum[1:0], mul_q[EXT-1:2]};

    m_d    = m_q;
    mul_d  = mul_q;
    acc_d  = acc_q;
    prev_d = prev_q;
    cnt_d  = cnt_q;
    c_d    = c_q;
    done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d    = {{2{signed_mode & a[WIDTH-1]}}, a};
          mul_d  = {{2{signed_mode & b[WIDTH-1]}}, b};
          acc_d  = '0;
          prev_d = 1'b0;
          cnt_d  = '0;
        end
      end
      RUN: begin
        acc_d  = acc_sh;
        mul_d  = mul_sh;
        prev_d = mul_q[1];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          c_d    = {acc_sh[WIDTH-3:0], mul_sh};
          done_d = 1'b1;
          cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q    <= '0;
      mul_q  <= '0;
      acc_q  <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      c_q    <= '0;
      done_q <= 1'b0;
    end else begin
      m_q    <= m_d;
      mul_q  <= mul_d;
      acc_q  <= acc_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      c_q    <= c_d;
      done_q <= done_d;
    end
  end

endmodule
